// File: rtl/noc_flit_pkg.sv
// Shared flit format definitions for the tile transmitter and the router flit parser.
package noc_flit_pkg;

    localparam int unsigned COORD_W    = 8;
    localparam int unsigned PAYLOAD_W  = 46;
    localparam int unsigned DEST_X_MSB = 63;
    localparam int unsigned DEST_X_LSB = 56;
    localparam int unsigned DEST_Y_MSB = 55;
    localparam int unsigned DEST_Y_LSB = 48;
    localparam int unsigned TYPE_MSB   = 47;
    localparam int unsigned TYPE_LSB   = 46;
    localparam int unsigned PAYLOAD_MSB = 45;

    typedef enum logic [1:0] {
        FLIT_SINGLE = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_BODY   = 2'b10,
        FLIT_TAIL   = 2'b11
    } flit_type_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    // Flit type from the position of the flit within its packet.
    function automatic flit_type_e flit_type_of(input logic first, input logic last);
        if (first && last) return FLIT_SINGLE;
        if (first)         return FLIT_HEAD;
        if (last)          return FLIT_TAIL;
        return FLIT_BODY;
    endfunction

    function automatic logic is_pkt_end(input flit_type_e t);
        return (t == FLIT_SINGLE) || (t == FLIT_TAIL);
    endfunction

endpackage

// File: rtl/noc_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module noc_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/noc_tile_flit_tx.sv
// Tile-side flit transmitter: packs command + payload words into typed flits
// and holds each flit in a single output register under router backpressure.
module noc_tile_flit_tx
    import noc_flit_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [COORD_W-1:0]    cmd_dest_x,
    input  logic [COORD_W-1:0]    cmd_dest_y,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [PAYLOAD_W-1:0]  data_in,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  busy,
    output logic [CNT_W-1:0]      flits_sent_count,
    output logic [CNT_W-1:0]      packets_sent_count,
    output logic [CNT_W-1:0]      stall_count,
    output logic                  len_err
);

    tx_state_e               state_q, state_d;
    logic [COORD_W-1:0]      dest_x_q, dest_y_q;
    logic [LEN_W-1:0]        remaining_q;
    logic                    first_q;
    logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
    logic                    valid_q;
    logic                    len_err_q;
    logic                    cmd_hs, data_hs, last_word;
    logic                    flit_acc, pkt_acc, stall_ev;
    flit_type_e              cur_type, out_type;

    assign cmd_hs    = cmd_valid && cmd_ready;
    assign data_hs   = data_valid && data_ready;
    assign last_word = (remaining_q == LEN_W'(1));
    assign cur_type  = flit_type_of(first_q, last_word);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= TX_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: if (cmd_hs && (cmd_len != '0)) state_d = TX_SEND;
            TX_SEND: if (data_hs && last_word)      state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // Handshake outputs; a payload word is taken only when the output slot frees.
    always_comb begin
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        case (state_q)
            TX_IDLE: cmd_ready  = 1'b1;
            TX_SEND: data_ready = !valid_q || ready_in;
            default: ;
        endcase
    end

    always_comb begin
        flit_d = '0;
        flit_d[DEST_X_MSB:DEST_X_LSB] = dest_x_q;
        flit_d[DEST_Y_MSB:DEST_Y_LSB] = dest_y_q;
        flit_d[TYPE_MSB:TYPE_LSB]     = cur_type;
        flit_d[PAYLOAD_MSB:0]         = data_in;
    end

    // Packet context and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_x_q    <= '0;
            dest_y_q    <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            flit_q      <= '0;
            valid_q     <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            if (cmd_hs) begin
                if (cmd_len == '0) begin
                    len_err_q <= 1'b1;
                end else begin
                    dest_x_q    <= cmd_dest_x;
                    dest_y_q    <= cmd_dest_y;
                    remaining_q <= cmd_len;
                    first_q     <= 1'b1;
                end
            end
            if (data_hs) begin
                flit_q      <= flit_d;
                valid_q     <= 1'b1;
                remaining_q <= remaining_q - LEN_W'(1);
                first_q     <= 1'b0;
            end else if (ready_in) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_type = flit_type_e'(flit_q[TYPE_MSB:TYPE_LSB]);
    assign flit_acc = valid_q && ready_in;
    assign pkt_acc  = flit_acc && is_pkt_end(out_type);
    assign stall_ev = valid_q && !ready_in;

    noc_sat_counter #(.WIDTH(CNT_W)) u_flits_cnt (
        .clk(clk), .reset(reset), .inc(flit_acc), .count(flits_sent_count)
    );
    noc_sat_counter #(.WIDTH(CNT_W)) u_pkts_cnt (
        .clk(clk), .reset(reset), .inc(pkt_acc), .count(packets_sent_count)
    );
    noc_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_ev), .count(stall_count)
    );

    assign flit_out  = flit_q;
    assign valid_out = valid_q;
    assign len_err   = len_err_q;
    assign busy      = (state_q == TX_SEND) || valid_q;

endmodule

// File: tb/tb_noc_tile_flit_tx.sv
// Directed self-checking bench for noc_tile_flit_tx.
module tb_noc_tile_flit_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_dest_x, cmd_dest_y;
    logic [7:0]  cmd_len;
    logic        data_valid;
    logic        data_ready;
    logic [45:0] data_in;
    logic [63:0] flit_out;
    logic        valid_out;
    logic        ready_in;
    logic        busy;
    logic [31:0] flits_sent_count, packets_sent_count, stall_count;
    logic        len_err;

    int vectors = 0;
    int miscompares = 0;

    noc_tile_flit_tx dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dest_x(cmd_dest_x), .cmd_dest_y(cmd_dest_y), .cmd_len(cmd_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .flit_out(flit_out), .valid_out(valid_out), .ready_in(ready_in),
        .busy(busy),
        .flits_sent_count(flits_sent_count),
        .packets_sent_count(packets_sent_count),
        .stall_count(stall_count),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] len);
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_dest_x = x;
        cmd_dest_y = y;
        cmd_len    = len;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check_eq("cmd_timeout", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [63:0] mk(input logic [7:0] x, input logic [7:0] y,
                                       input logic [1:0] t, input logic [45:0] p);
        return {x, y, t, p};
    endfunction

    logic [63:0] rx[$];
    logic [63:0] held;
    logic        stalled, hs;
    int          sent, stall_exp, cyc;

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_dest_x = '0;
        cmd_dest_y = '0;
        cmd_len    = '0;
        data_valid = 1'b0;
        data_in    = '0;
        ready_in   = 1'b1;
        #12 reset  = 1'b0;
        tick();

        // Reset state
        check_eq("rst_valid", 64'(valid_out), 64'd0);
        check_eq("rst_flit", flit_out, 64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_data_ready", 64'(data_ready), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_cnts", {flits_sent_count, packets_sent_count | stall_count}, 64'd0);
        check_eq("rst_len_err", 64'(len_err), 64'd0);

        // Single flit
        send_cmd(8'd2, 8'd3, 8'd1);
        data_valid = 1'b1;
        data_in    = 46'h1234;
        tick();
        data_valid = 1'b0;
        check_eq("single_flit", flit_out, 64'h0203_0000_0000_1234);
        check_eq("single_valid", 64'(valid_out), 64'd1);
        check_eq("single_cmd_ready", 64'(cmd_ready), 64'd1);
        tick();
        check_eq("single_valid_drop", 64'(valid_out), 64'd0);
        check_eq("single_flits", 64'(flits_sent_count), 64'd1);
        check_eq("single_pkts", 64'(packets_sent_count), 64'd1);

        // 4-flit packet, full throughput
        send_cmd(8'd1, 8'd1, 8'd4);
        for (int i = 1; i <= 4; i++) begin
            data_valid = 1'b1;
            data_in    = 46'(i);
            tick();
            check_eq($sformatf("p4_flit%0d", i), flit_out,
                     mk(8'd1, 8'd1, (i == 1) ? 2'b01 : (i == 4) ? 2'b11 : 2'b10, 46'(i)));
            check_eq($sformatf("p4_valid%0d", i), 64'(valid_out), 64'd1);
            check_eq($sformatf("p4_cmd_ready%0d", i), 64'(cmd_ready), (i == 4) ? 64'd1 : 64'd0);
        end
        data_valid = 1'b0;
        tick();
        check_eq("p4_valid_drop", 64'(valid_out), 64'd0);
        check_eq("p4_flits", 64'(flits_sent_count), 64'd5);
        check_eq("p4_pkts", 64'(packets_sent_count), 64'd2);

        // 20-flit packet under periodic backpressure
        send_cmd(8'd5, 8'd6, 8'd20);
        sent = 0;
        stall_exp = 0;
        cyc = 0;
        while ((sent < 20 || valid_out) && cyc < 300) begin
            ready_in   = ((cyc % 10) < 6);
            data_valid = (sent < 20);
            data_in    = 46'(sent);
            #0;
            if (valid_out && ready_in) rx.push_back(flit_out);
            stalled = valid_out && !ready_in;
            if (stalled) begin
                stall_exp++;
                held = flit_out;
                check_eq("bp_data_ready", 64'(data_ready), 64'd0);
            end
            hs = data_valid && data_ready;
            tick();
            if (hs) sent++;
            if (stalled) begin
                check_eq("bp_hold_flit", flit_out, held);
                check_eq("bp_hold_valid", 64'(valid_out), 64'd1);
            end
            cyc++;
        end
        if (cyc >= 300) check_eq("bp_timeout", 64'(cyc), 64'd0);
        ready_in   = 1'b1;
        data_valid = 1'b0;
        check_eq("bp_rx_count", 64'(rx.size()), 64'd20);
        for (int i = 0; i < rx.size() && i < 20; i++) begin
            check_eq($sformatf("bp_flit%0d", i), rx[i],
                     mk(8'd5, 8'd6, (i == 0) ? 2'b01 : (i == 19) ? 2'b11 : 2'b10, 46'(i)));
        end
        check_eq("bp_flits", 64'(flits_sent_count), 64'd25);
        check_eq("bp_pkts", 64'(packets_sent_count), 64'd3);
        check_eq("bp_stalls", 64'(stall_count), 64'(stall_exp));
        check_eq("bp_stall_nonzero", 64'(stall_exp > 0), 64'd1);

        // Zero-length command
        send_cmd(8'd0, 8'd0, 8'd0);
        check_eq("len0_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("len0_valid", 64'(valid_out), 64'd0);
        check_eq("len0_err", 64'(len_err), 64'd1);
        tick();
        check_eq("len0_valid_later", 64'(valid_out), 64'd0);
        check_eq("len0_err_sticky", 64'(len_err), 64'd1);
        send_cmd(8'd7, 8'd8, 8'd2);
        data_valid = 1'b1;
        data_in    = 46'h2a;
        tick();
        check_eq("len2_head", flit_out, mk(8'd7, 8'd8, 2'b01, 46'h2a));
        data_in = 46'h2b;
        tick();
        data_valid = 1'b0;
        check_eq("len2_tail", flit_out, mk(8'd7, 8'd8, 2'b11, 46'h2b));
        tick();
        check_eq("len2_flits", 64'(flits_sent_count), 64'd27);
        check_eq("len2_pkts", 64'(packets_sent_count), 64'd4);
        check_eq("len2_err_sticky", 64'(len_err), 64'd1);

        // Reset mid-packet after two of five flits
        send_cmd(8'd9, 8'd9, 8'd5);
        data_valid = 1'b1;
        data_in    = 46'd100;
        tick();
        data_in = 46'd101;
        tick();
        data_valid = 1'b0;
        check_eq("mid_valid_before", 64'(valid_out), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_valid_async", 64'(valid_out), 64'd0);
        check_eq("mid_cnts", {flits_sent_count, packets_sent_count | stall_count}, 64'd0);
        check_eq("mid_len_err", 64'(len_err), 64'd0);
        #1 reset = 1'b0;
        tick();
        check_eq("mid_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("mid_busy", 64'(busy), 64'd0);
        send_cmd(8'd1, 8'd2, 8'd1);
        data_valid = 1'b1;
        data_in    = 46'h77;
        tick();
        data_valid = 1'b0;
        check_eq("mid_single", flit_out, mk(8'd1, 8'd2, 2'b00, 46'h77));
        tick();
        check_eq("mid_flits", 64'(flits_sent_count), 64'd1);

        // Back-to-back len=3 then len=1
        send_cmd(8'd3, 8'd4, 8'd3);
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            data_in    = 46'(10 + i);
            tick();
            check_eq($sformatf("b2b_flit%0d", i), flit_out,
                     mk(8'd3, 8'd4, (i == 0) ? 2'b01 : (i == 2) ? 2'b11 : 2'b10, 46'(10 + i)));
        end
        data_valid = 1'b0;
        check_eq("b2b_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("b2b_tail_pending", 64'(valid_out), 64'd1);
        send_cmd(8'd3, 8'd4, 8'd1);
        check_eq("b2b_gap", 64'(valid_out), 64'd0);
        data_valid = 1'b1;
        data_in    = 46'd20;
        tick();
        data_valid = 1'b0;
        check_eq("b2b_single", flit_out, mk(8'd3, 8'd4, 2'b00, 46'd20));
        check_eq("b2b_single_valid", 64'(valid_out), 64'd1);
        tick();
        check_eq("b2b_pkts", 64'(packets_sent_count), 64'd3);
        check_eq("b2b_flits", 64'(flits_sent_count), 64'd5);
        check_eq("b2b_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/noc_tile_flit_tx.md
# noc_tile_flit_tx

Tile-side flit transmitter that drives one router input port (normally the local port) over the valid/ready flit handshake. It accepts a packet command (destination, length) and a stream of payload words from the tile, then formats 64-bit flits with HEAD/BODY/TAIL/SINGLE type. It holds each flit stable under router backpressure and keeps throughput, stall and error statistics.

## Interface
Parameters:
- FLIT_WIDTH, 64, flit width; only 64 is supported because the field layout is fixed
- LEN_W, 8, width of packet length field; maximum packet is 2^LEN_W-1 flits
- CNT_W, 32, width of statistics counters

Ports (one clock `clk`; `reset` is asynchronous, active-high):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cmd_valid  in  1  packet command valid
- cmd_ready  out  1  command accepted when both are high
- cmd_dest_x  in  8  destination X
- cmd_dest_y  in  8  destination Y
- cmd_len  in  LEN_W  flit count of the packet; 0 is illegal
- data_valid  in  1  payload word valid
- data_ready  out  1  payload word accepted when both are high
- data_in  in  46  payload word
- flit_out  out  FLIT_WIDTH  flit to router input (flit_in_*)
- valid_out  out  1  flit valid (valid_in_*)
- ready_in  in  1  router acceptance (ready_out_*)
- busy  out  1  packet in progress or flit pending
- flits_sent_count  out  CNT_W  flits accepted by router
- packets_sent_count  out  CNT_W  TAIL/SINGLE flits accepted
- stall_count  out  CNT_W  cycles with valid_out=1 and ready_in=0
- len_err  out  1  sticky; set when a command with len=0 is accepted

## Operation
- Flit layout:
  - [63:56] dest_x
  - [55:48] dest_y
  - [47:46] type: 00 SINGLE, 01 HEAD, 10 BODY, 11 TAIL
  - [45:0] payload
- FSM states IDLE and SEND.
- IDLE:
  - cmd_ready=1.
  - On a cmd handshake with len≥1: latch dest, set remaining=len and first=1, go to SEND.
  - On a cmd handshake with len=0: set len_err, remain in IDLE, emit no flit.
- SEND:
  - cmd_ready=0; data_ready = !valid_out || ready_in.
  - Each data handshake loads the output register with the flit built from the latched dest and data_in, then decrements remaining and clears first.
  - Type is SINGLE if first and remaining==1; HEAD if first; TAIL if remaining==1; otherwise BODY.
  - The handshake that loads the last flit returns the FSM to IDLE.
- Output register:
  - Load when (!valid_out || ready_in) and a data handshake occurs.
  - Clear valid_out when ready_in=1 and there is no new load.
  - flit_out and valid_out do not change while valid_out=1 and ready_in=0.
- Counters saturate at all-ones and never wrap.
  - flits_sent_count increments on valid_out && ready_in.
  - packets_sent_count increments on the same event when the type is SINGLE or TAIL.
  - stall_count increments on valid_out && !ready_in.
- busy = (state==SEND) || valid_out.

## Timing
- Reset values: state IDLE, valid_out=0, flit_out=0, cmd_ready=1, data_ready=0, busy=0, all counters 0, len_err=0.
- Latency: a flit appears on flit_out/valid_out the cycle after its data handshake.
- Throughput: with ready_in held at 1 and data_valid held at 1, one flit per cycle with no bubbles inside a packet.
- One dead cycle between packets: cmd_ready rises the cycle after the last data handshake. The previous TAIL may still be pending in the output register while the next command is accepted.
- Simultaneous ready_in and new load: the old flit is counted, the new flit replaces it in the same edge, and valid_out stays 1.
- Backpressure: data_ready=0 whenever valid_out=1 and ready_in=0. No flit is ever dropped or duplicated.
- Reset asserted mid-packet: valid_out drops asynchronously and the partial packet is abandoned (no TAIL is sent). After release the block is in IDLE.

## Structure
- Shared package noc_flit_pkg holds:
  - flit field offsets and widths (DEST_X_MSB etc.)
  - the flit type enum (FLIT_SINGLE, FLIT_HEAD, FLIT_BODY, FLIT_TAIL)
  - PAYLOAD_W=46
- The router's flit parser reuses the same package.
- One natural sub-module: noc_sat_counter (parameter width, inc input, saturating). It is instantiated three times.

## Test plan
- Single flit: cmd (2,3) len=1 and data 46'h1234, ready_in=1 → one cycle later flit_out={8'h02,8'h03,2'b00,46'h1234} with valid_out=1 for exactly 1 cycle; flits_sent_count=1, packets_sent_count=1.
- 4-flit packet, ready_in=1, data 1..4 → types 01,10,10,11 on 4 consecutive cycles with payloads 1..4 in order; cmd_ready high again the cycle after the 4th data handshake.
- 20-flit packet with ready_in following the pattern (cycle%10)<6 → flit_out stable in every cycle where valid_out&&!ready_in; payloads 0..19 delivered once each; flits_sent_count=20; stall_count equals the number of cycles with a pending flit and low ready_in.
- cmd len=0 → accepted in one cycle; no valid_out; len_err=1 and it remains set; the next len=2 packet sends HEAD then TAIL normally.
- Reset pulse after 2 of 5 flits are accepted → valid_out=0 immediately; all counters 0; after release cmd_ready=1; a new len=1 packet emits a SINGLE.
- Back-to-back packets len=3 and len=1 with ready_in=1 → sequence HEAD, BODY, TAIL, SINGLE with exactly one idle valid_out cycle between them; packets_sent_count=2.
